// File: rtl/gc_ram_arbiter_pkg.sv
// Shared sizing defaults and port-index encoding for the status-SRAM read arbiter,
// its interface and the controller cores that talk to it.
package gc_ram_arbiter_pkg;

  localparam int NUM_PORTS_DEF = 4;
  localparam int ADDR_BITS_DEF = 6;
  localparam int SEL_BITS_DEF  = $clog2(NUM_PORTS_DEF);

  // Upper SRAM address bits select the owning controller core.
  typedef enum logic [SEL_BITS_DEF-1:0] {
    PORT_0 = 2'd0,
    PORT_1 = 2'd1,
    PORT_2 = 2'd2,
    PORT_3 = 2'd3
  } port_e;

endpackage

// File: rtl/gc_ram_arbiter_if.sv
// Read-port bundle between the controller cores, the arbiter and the status SRAM.
// The slave side is the arbiter; the master side is the cores plus SRAM.
interface gc_ram_arbiter_if
  import gc_ram_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  parameter int SEL_BITS  = SEL_BITS_DEF
) ();

  logic [NUM_PORTS-1:0]           req;
  logic [NUM_PORTS*ADDR_BITS-1:0] addr;
  logic [SEL_BITS+ADDR_BITS-1:0]  ram_addr;
  logic                           ram_data;
  logic                           data_out;
  logic [NUM_PORTS-1:0]           ack;

  modport slave (
    input  req, addr, ram_data,
    output ram_addr, data_out, ack
  );

  modport master (
    output req, addr, ram_data,
    input  ram_addr, data_out, ack
  );

endinterface

// File: rtl/gc_ram_arbiter_rr_pick.sv
// Combinational round-robin pick: first eligible port searching upward from last+1,
// wrapping modulo NUM_PORTS (a power of two, so the wrap is free).
module gc_rr_pick
  import gc_ram_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int SEL_BITS  = SEL_BITS_DEF
) (
  input  logic [NUM_PORTS-1:0] elig,
  input  logic [SEL_BITS-1:0]  last,
  output logic                 vld,
  output logic [SEL_BITS-1:0]  idx
);

  logic [SEL_BITS-1:0] cand;

  // Walk from lowest to highest priority so the last hit is the winner.
  always_comb begin
    vld  = 1'b0;
    idx  = last;
    cand = '0;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      cand = last + SEL_BITS'(i);
      if (elig[cand]) begin
        vld = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/gc_ram_arbiter.sv
// Two-stage request-driven round-robin arbiter for the status-SRAM read port.
// Define GC_ARB_FIXED_SLOT_EN to build the legacy fixed timeslice instead.
module gc_ram_arbiter
  import gc_ram_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  parameter int SEL_BITS  = SEL_BITS_DEF
) (
  input  logic          clk,
  input  logic          reset,
  gc_ram_arbiter_if.slave bus
);

  logic [NUM_PORTS-1:0]          issue_p1;
  logic [SEL_BITS+ADDR_BITS-1:0] ram_addr_p1;
  logic [NUM_PORTS-1:0]          ack_p2;
  logic                          data_p2;

`ifdef GC_ARB_FIXED_SLOT_EN

  logic [SEL_BITS-1:0] slot_p0;

  // Stage 1: fixed timeslice issue, requests ignored
  always_ff @(posedge clk) begin
    if (!reset) begin
      slot_p0     <= '0;
      issue_p1    <= '0;
      ram_addr_p1 <= '0;
    end else begin
      slot_p0     <= slot_p0 + SEL_BITS'(1);
      issue_p1    <= NUM_PORTS'(1) << slot_p0;
      ram_addr_p1 <= {slot_p0, bus.addr[slot_p0*ADDR_BITS +: ADDR_BITS]};
    end
  end

`else

  logic [SEL_BITS-1:0]  last_p1;
  logic [SEL_BITS-1:0]  win;
  logic                 win_vld;
  logic [NUM_PORTS-1:0] elig;

  // A port granted last cycle is still in flight and sits this cycle out.
  assign elig = bus.req & ~issue_p1;

  gc_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .SEL_BITS  (SEL_BITS)
  ) u_pick (
    .elig (elig),
    .last (last_p1),
    .vld  (win_vld),
    .idx  (win)
  );

  // Stage 1: arbitrate and issue the SRAM address
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_p1     <= SEL_BITS'(NUM_PORTS - 1);
      issue_p1    <= '0;
      ram_addr_p1 <= '0;
    end else if (win_vld) begin
      last_p1     <= win;
      issue_p1    <= NUM_PORTS'(1) << win;
      ram_addr_p1 <= {win, bus.addr[win*ADDR_BITS +: ADDR_BITS]};
    end else begin
      issue_p1    <= '0;
    end
  end

`endif

  // Stage 2: capture SRAM data and acknowledge the issuing port
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_p2 <= 1'b0;
      ack_p2  <= '0;
    end else begin
      data_p2 <= bus.ram_data;
      ack_p2  <= issue_p1;
    end
  end

  assign bus.ram_addr = ram_addr_p1;
  assign bus.data_out = data_p2;
  assign bus.ack      = ack_p2;

endmodule

// File: tb/tb_gc_ram_arbiter.sv
// Self-checking bench for gc_ram_arbiter: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the arbitration rules.
module tb_gc_ram_arbiter;

  localparam int NP = 4;
  localparam int AB = 6;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic mem [256];

  int n_checks = 0;
  int n_fail   = 0;

  gc_ram_arbiter_if #(.NUM_PORTS(NP), .ADDR_BITS(AB), .SEL_BITS(2)) bus ();

  gc_ram_arbiter #(.NUM_PORTS(NP), .ADDR_BITS(AB), .SEL_BITS(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.ram_data = mem[bus.ram_addr];

  // Behavioural model: ports as integers, -1 meaning "nobody".
  int         m_last;
  int         m_issue;
  int         m_slot;
  logic [7:0] m_ram_addr;
  logic [3:0] m_ack;
  logic       m_data;

  task automatic model_edge();
    int winner;
    if (!reset) begin
      m_ram_addr = 8'h00;
      m_ack      = 4'h0;
      m_data     = 1'b0;
      m_issue    = -1;
      m_last     = NP - 1;
      m_slot     = 0;
    end else begin
      m_data = mem[m_ram_addr];
      m_ack  = (m_issue >= 0) ? 4'(1 << m_issue) : 4'h0;
      winner = -1;
`ifdef GC_ARB_FIXED_SLOT_EN
      winner = m_slot;
      m_slot = (m_slot + 1) % NP;
`else
      for (int k = 1; k <= NP; k++) begin
        int p;
        p = (m_last + k) % NP;
        if (winner < 0 && bus.req[p] && p != m_issue) winner = p;
      end
`endif
      m_issue = winner;
      if (winner >= 0) begin
        m_ram_addr = {2'(winner), bus.addr[winner*AB +: AB]};
        m_last     = winner;
      end
    end
  endtask

  // Advance one clock; the model sees the same inputs the DUT samples.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    bus.req  = '0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    bus.req  = '0;
    bus.addr = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({bus.ram_addr, bus.ack, bus.data_out} !== 13'h0) begin
        n_fail++;
        $display("FAIL reset_hold cyc=%0d: ram_addr=%h ack=%b data_out=%b, required all 0", i, bus.ram_addr, bus.ack, bus.data_out);
      end
    end
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++;
      if ({bus.ram_addr, bus.ack, bus.data_out} !== 13'h0) begin
        n_fail++;
        $display("FAIL reset_idle cyc=%0d: ram_addr=%h ack=%b data_out=%b, required all 0", i, bus.ram_addr, bus.ack, bus.data_out);
      end
    end
  endtask

  task automatic test_single_port();
    do_reset();
    mem[8'h95]        = 1'b1;
    bus.addr[2*AB +: AB] = 6'h15;
    bus.req           = 4'b0100;
    step();
    n_checks++;
    if (bus.ram_addr !== 8'h95) begin
      n_fail++;
      $display("FAIL single_addr: ram_addr=%h, required 95", bus.ram_addr);
    end
    step();
    n_checks++;
    if (bus.ack !== 4'b0100 || bus.data_out !== 1'b1) begin
      n_fail++;
      $display("FAIL single_ack: ack=%b data_out=%b, required 0100/1", bus.ack, bus.data_out);
    end
    for (int n = 3; n <= 10; n++) begin
      step();
      n_checks++;
      if (bus.ack !== ((n % 2 == 0) ? 4'b0100 : 4'b0000)) begin
        n_fail++;
        $display("FAIL single_repeat edge=%0d: ack=%b, required %b", n, bus.ack, (n % 2 == 0) ? 4'b0100 : 4'b0000);
      end
    end
    bus.req = '0;
  endtask

  task automatic test_all_ports();
    int cnt [NP];
    do_reset();
    for (int p = 0; p < NP; p++) begin
      bus.addr[p*AB +: AB] = 6'(p * 16 + $urandom_range(0, 15));
      cnt[p] = 0;
    end
    bus.req = 4'hF;
    for (int n = 1; n <= 16; n++) begin
      step();
      n_checks++;
      if (bus.ram_addr[7:6] !== 2'((n - 1) % NP)) begin
        n_fail++;
        $display("FAIL all_order edge=%0d: granted port=%0d, required %0d", n, bus.ram_addr[7:6], (n - 1) % NP);
      end
      if (n >= 2) begin
        n_checks++;
        if (bus.ack !== 4'(1 << ((n - 2) % NP)) || bus.data_out !== m_data) begin
          n_fail++;
          $display("FAIL all_ack edge=%0d: ack=%b data=%b, required %b/%b", n, bus.ack, bus.data_out, 4'(1 << ((n - 2) % NP)), m_data);
        end
        for (int p = 0; p < NP; p++) if (bus.ack[p]) cnt[p]++;
      end
    end
    for (int p = 0; p < NP; p++) begin
      n_checks++;
      if (cnt[p] < 3) begin
        n_fail++;
        $display("FAIL all_starve port=%0d: acks=%0d, required >=3", p, cnt[p]);
      end
    end
    bus.req = '0;
  endtask

  task automatic test_late_drop();
    int acks;
    do_reset();
    acks = 0;
    bus.req = 4'b0010;
    step();
    bus.req = 4'b0000;
    for (int n = 0; n < 10; n++) begin
      step();
      if (bus.ack[1]) acks++;
      n_checks++;
      if (bus.ack !== m_ack || bus.ram_addr !== m_ram_addr) begin
        n_fail++;
        $display("FAIL late_drop_cycle n=%0d: ack=%b addr=%h, required %b/%h", n, bus.ack, bus.ram_addr, m_ack, m_ram_addr);
      end
    end
    n_checks++;
    if (acks !== 1) begin
      n_fail++;
      $display("FAIL late_drop_count: ack[1] pulses=%0d, required 1", acks);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.req = 4'b1000;
    step();
    n_checks++;
    if (bus.ram_addr[7:6] !== 2'd3) begin
      n_fail++;
      $display("FAIL mid_grant: port=%0d, required 3", bus.ram_addr[7:6]);
    end
    reset = 1'b0;
    step();
    step();
    n_checks++;
    if (bus.ack !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_noack: ack=%b, required 0000", bus.ack);
    end
    reset   = 1'b1;
    bus.req = 4'hF;
    step();
    n_checks++;
    if (bus.ram_addr[7:6] !== 2'd0 || bus.ack !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_restart: port=%0d ack=%b, required 0/0000", bus.ram_addr[7:6], bus.ack);
    end
    bus.req = '0;
  endtask

  task automatic test_fixed_slot();
    do_reset();
    bus.req = '0;
    step();
    for (int n = 2; n <= 12; n++) begin
      step();
      n_checks++;
      if (bus.ack !== 4'(1 << ((n - 2) % NP))) begin
        n_fail++;
        $display("FAIL fixed_slot edge=%0d: ack=%b, required %b", n, bus.ack, 4'(1 << ((n - 2) % NP)));
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] prev_ack;
    prev_ack = 4'h0;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 49) != 0);
      if ($urandom_range(0, 2) == 0) bus.req = 4'($urandom);
      if ($urandom_range(0, 3) == 0) bus.addr = 24'($urandom);
      step();
      n_checks++;
      if (bus.ram_addr !== m_ram_addr || bus.ack !== m_ack || bus.data_out !== m_data) begin
        n_fail++;
        $display("FAIL random n=%0d: addr=%h ack=%b data=%b, required %h/%b/%b", n, bus.ram_addr, bus.ack, bus.data_out, m_ram_addr, m_ack, m_data);
      end
      n_checks++;
      if (!$onehot0(bus.ack) || (bus.ack & prev_ack) != 4'h0) begin
        n_fail++;
        $display("FAIL random_ack_shape n=%0d: ack=%b prev=%b", n, bus.ack, prev_ack);
      end
      prev_ack = bus.ack;
    end
    reset   = 1'b1;
    bus.req = '0;
  endtask

  initial begin
    bus.req  = '0;
    bus.addr = '0;
    for (int i = 0; i < 256; i++) mem[i] = 1'($urandom);
    mem[0] = 1'b0;
    test_reset();
`ifdef GC_ARB_FIXED_SLOT_EN
    test_fixed_slot();
`else
    test_single_port();
    test_all_ports();
    test_late_drop();
    test_reset_mid();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
